// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/loader memory arbiter: FSM states, access owner,
// and the loader wait-counter width with its saturating increment.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_e;

    localparam int              WAIT_W   = 8;
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between CPU and loader.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed CPU priority with a loader starvation override.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic              cpu_req,
    input  logic              ld_req,
`ifdef MEM_ARB_RR_EN
    input  owner_e            last_owner,
`else
    input  logic [WAIT_W-1:0] wait_cnt,
`endif
    output logic              gnt_vld,
    output owner_e            gnt_owner
);

`ifndef MEM_ARB_RR_EN
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(STARVE_LIMIT);
    logic starved;
    assign starved = (wait_cnt >= LIMIT);
`endif

    always_comb begin
        gnt_vld   = cpu_req | ld_req;
        gnt_owner = OWN_CPU;
`ifdef MEM_ARB_RR_EN
        // On a tie the side that did not win last time goes next.
        if (ld_req && (!cpu_req || last_owner == OWN_CPU))
            gnt_owner = OWN_LD;
`else
        if (ld_req && (starved || !cpu_req))
            gnt_owner = OWN_LD;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, loader) arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin instead of fixed priority with starvation override.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [WIDTH-1:0]      cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [WIDTH-1:0]      ld_wdata,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [WIDTH-1:0]      ld_rdata,
    input  logic                  ld_lock,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0]      ld_rdata_q, ld_rdata_d;

    logic   arb_cycle;
    logic   cpu_elig;
    logic   pick_vld;
    owner_e pick_owner;

`ifdef MEM_ARB_RR_EN
    owner_e last_q, last_d;
`else
    logic [WAIT_W-1:0] wait_q, wait_d;
`endif

    // The lock only masks new CPU requests; an access already latched completes.
    assign cpu_elig  = cpu_req & ~ld_lock;
    assign arb_cycle = (state_q != ACCESS);

    arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .cpu_req   (cpu_elig),
        .ld_req    (ld_req),
`ifdef MEM_ARB_RR_EN
        .last_owner(last_q),
`else
        .wait_cnt  (wait_q),
`endif
        .gnt_vld   (pick_vld),
        .gnt_owner (pick_owner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: state_d = pick_vld ? ACCESS : IDLE;
            ACCESS:     state_d = RESP;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt    = 1'b0;
        ld_gnt     = 1'b0;
        cpu_rvalid = 1'b0;
        ld_rvalid  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            ACCESS: begin
                mem_en  = 1'b1;
                mem_we  = we_q;
                cpu_gnt = (owner_q == OWN_CPU);
                ld_gnt  = (owner_q == OWN_LD);
            end
            RESP: begin
                cpu_rvalid = (owner_q == OWN_CPU);
                ld_rvalid  = (owner_q == OWN_LD);
            end
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign ld_rdata  = ld_rvalid  ? mem_rdata : ld_rdata_q;

    // Winner's request fields are captured at the arbitration edge.
    always_comb begin
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        ld_rdata_d  = ld_rvalid  ? mem_rdata : ld_rdata_q;
        if (arb_cycle && pick_vld) begin
            owner_d = pick_owner;
            if (pick_owner == OWN_LD) begin
                we_d    = ld_we;
                addr_d  = ld_addr;
                wdata_d = ld_wdata;
            end else begin
                we_d    = cpu_we;
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Reset value of OWN_LD makes the CPU win the first tie.
    always_comb begin
        last_d = last_q;
        if (arb_cycle && pick_vld) last_d = pick_owner;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= OWN_LD;
        else      last_q <= last_d;
    end
`else
    always_comb begin
        wait_d = wait_q;
        if (arb_cycle && pick_vld) begin
            if (pick_owner == OWN_LD) wait_d = '0;
            else if (ld_req)          wait_d = sat_inc(wait_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_q <= '0;
        else      wait_q <= wait_d;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int AW = 10;
    localparam int SL = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
    logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
    logic [W-1:0]  cpu_wdata = '0, ld_wdata = '0;
    logic cpu_gnt, cpu_rvalid, cpu_stall, ld_gnt, ld_rvalid, mem_en, mem_we;
    logic [W-1:0]  cpu_rdata, ld_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_lock(ld_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous memory device; unwritten words hold a fixed pattern.
    function automatic logic [W-1:0] init_val(input logic [AW-1:0] a);
        return (a == 10'h010) ? 32'hDEADBEEF : (32'hA5A5_0000 | W'(a));
    endfunction

    logic [W-1:0] phys [0:(1<<AW)-1];
    bit           written [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                phys[mem_addr]    <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? phys[mem_addr] : init_val(mem_addr);
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in its access cycle, one in its response cycle.
    typedef struct packed {
        logic          v;
        logic          ld;
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wd;
        logic [W-1:0]  rd;
    } txn_t;

    txn_t          m_acc, m_resp;
    logic [W-1:0]  mm [0:(1<<AW)-1];
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_wdata;
    int            m_wait;
    bit            m_rr_ld_next;
    logic [W-1:0]  m_rd [0:1];
    bit            m_rd_ok [0:1];

    task automatic model_reset();
        m_acc = '0; m_resp = '0; m_addr = '0; m_wdata = '0;
        m_wait = 0; m_rr_ld_next = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0; m_rd_ok[0] = 1'b1; m_rd_ok[1] = 1'b1;
    endtask

    task automatic model_step();
        txn_t nx;
        logic cpu_p, ld_win;
        if (!rst) return;
        m_resp = m_acc;
        if (m_acc.v) begin
            if (m_acc.we) begin
                mm[m_acc.addr] = m_acc.wd;
                m_rd_ok[m_acc.ld] = 1'b0;
            end else begin
                m_resp.rd = mm[m_acc.addr];
                m_rd[m_acc.ld] = m_resp.rd;
                m_rd_ok[m_acc.ld] = 1'b1;
            end
        end
        nx = '0;
        cpu_p = cpu_req && !ld_lock;
        if (!m_acc.v && (cpu_p || ld_req)) begin
`ifdef MEM_ARB_RR_EN
            ld_win = ld_req && (!cpu_p || m_rr_ld_next);
            m_rr_ld_next = !ld_win;
`else
            ld_win = ld_req && (!cpu_p || m_wait >= SL);
            if (ld_win)      m_wait = 0;
            else if (ld_req) m_wait = (m_wait < 255) ? m_wait + 1 : 255;
`endif
            nx.v    = 1'b1;
            nx.ld   = ld_win;
            nx.we   = ld_win ? ld_we : cpu_we;
            nx.addr = ld_win ? ld_addr : cpu_addr;
            nx.wd   = ld_win ? ld_wdata : cpu_wdata;
            m_addr  = nx.addr;
            m_wdata = nx.wd;
        end
        m_acc = nx;
    endtask

    task automatic check_all();
        logic ec, el;
        ec = m_acc.v && !m_acc.ld;
        el = m_acc.v && m_acc.ld;
        chk("cpu_gnt", cpu_gnt, ec);
        chk("ld_gnt", ld_gnt, el);
        chk("mem_en", mem_en, m_acc.v);
        chk("mem_we", mem_we, m_acc.v && m_acc.we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("cpu_stall", cpu_stall, cpu_req && !ec);
        chk("cpu_rvalid", cpu_rvalid, m_resp.v && !m_resp.ld);
        chk("ld_rvalid", ld_rvalid, m_resp.v && m_resp.ld);
        if (m_rd_ok[0]) chk("cpu_rdata", cpu_rdata, m_rd[0]);
        if (m_rd_ok[1]) chk("ld_rdata", ld_rdata, m_rd[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 10'h3FF;
            1:       return 10'h010;
            default: return AW'($urandom_range(0, 15));
        endcase
    endfunction

    logic [7:0] seq;
    int         n;
    bit         cpu_pend, ld_pend;
    localparam logic [7:0] EXP_SEQ =
`ifdef MEM_ARB_RR_EN
        8'h55;
`else
        8'h11;
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) mm[i] = init_val(AW'(i));
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_cpu_rdata", cpu_rdata, '0);
        chk("rst_cpu_gnt", cpu_gnt, 1'b0);

        // Single CPU read of a known word
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        cycle();
        chk("rd_gnt_t1", cpu_gnt, 1'b1);
        chk("rd_addr_t1", mem_addr, 10'h010);
        cpu_req = 1'b0;
        cycle();
        chk("rd_rvalid_t2", cpu_rvalid, 1'b1);
        chk("rd_rdata_t2", cpu_rdata, 32'hDEADBEEF);
        cycle();
        chk("rd_rdata_hold", cpu_rdata, 32'hDEADBEEF);
        chk("rd_rvalid_low", cpu_rvalid, 1'b0);

        // Both requesters held high: grant order
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h001;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 10'h002;
        seq = '0; n = 0;
        for (int k = 0; k < 40 && n < 8; k++) begin
            cycle();
            if (cpu_gnt || ld_gnt) begin
                seq = {seq[6:0], ld_gnt};
                n++;
            end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        chk("grant_count", n, 8);
        chk("grant_order", seq, EXP_SEQ);
        cycle(); cycle();

        // Boot lock: loader write proceeds, CPU stalls
        ld_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'h3FF; ld_wdata = 32'h5;
        cycle();
        chk("lock_ld_gnt", ld_gnt, 1'b1);
        chk("lock_cpu_gnt", cpu_gnt, 1'b0);
        chk("lock_mem_we", mem_we, 1'b1);
        chk("lock_mem_addr", mem_addr, 10'h3FF);
        chk("lock_mem_wdata", mem_wdata, 32'h5);
        chk("lock_stall_a", cpu_stall, 1'b1);
        ld_req = 1'b0;
        cycle();
        chk("lock_ld_rvalid", ld_rvalid, 1'b1);
        chk("lock_stall_b", cpu_stall, 1'b1);
        cycle();
        chk("lock_cpu_gnt_idle", cpu_gnt, 1'b0);
        chk("lock_stall_c", cpu_stall, 1'b1);
        cpu_req = 1'b0; ld_lock = 1'b0;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 10'h3FF;
        cycle();
        chk("rb_ld_gnt", ld_gnt, 1'b1);
        ld_req = 1'b0;
        cycle();
        chk("rb_ld_rdata", ld_rdata, 32'h5);

        // Reset in the middle of an access
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        cycle();
        chk("ra_gnt", cpu_gnt, 1'b1);
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("ra_gnt_off", cpu_gnt, 1'b0);
        chk("ra_mem_en_off", mem_en, 1'b0);
        chk("ra_mem_addr_off", mem_addr, '0);
        chk("ra_ld_rdata_off", ld_rdata, '0);
        cycle();
        chk("ra_no_rvalid", cpu_rvalid, 1'b0);
        rst = 1'b1;
        cycle();
        chk("ra_regrant", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        cycle();
        chk("ra_rdata", cpu_rdata, 32'hDEADBEEF);

        // Random traffic from protocol-following requesters
        cpu_pend = 1'b0; ld_pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (cpu_pend && cpu_gnt) cpu_pend = 1'b0;
            else if (cpu_pend && $urandom_range(0, 19) == 0) cpu_pend = 1'b0;
            if (!cpu_pend && $urandom_range(0, 2) == 0) begin
                cpu_pend = 1'b1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wdata = $urandom();
            end
            if (ld_pend && ld_gnt) ld_pend = 1'b0;
            else if (ld_pend && $urandom_range(0, 19) == 0) ld_pend = 1'b0;
            if (!ld_pend && $urandom_range(0, 2) == 0) begin
                ld_pend = 1'b1; ld_we = 1'($urandom_range(0, 1));
                ld_addr = rand_addr(); ld_wdata = $urandom();
            end
            if ($urandom_range(0, 29) == 0) ld_lock = ~ld_lock;
            cpu_req = cpu_pend;
            ld_req  = ld_pend;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, maximum loader wait cycles under fixed priority; legal range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have CPU request ports: cpu_req in 1; cpu_we in 1; cpu_addr in ADDR_WIDTH; cpu_wdata in WIDTH.
REQ-007 SHALL have CPU response ports: cpu_gnt out 1; cpu_rvalid out 1; cpu_rdata out WIDTH; cpu_stall out 1 (high while cpu_req is pending and not yet granted).
REQ-008 SHALL have loader ports: ld_req in 1; ld_we in 1; ld_addr in ADDR_WIDTH; ld_wdata in WIDTH; ld_gnt out 1; ld_rvalid out 1; ld_rdata out WIDTH.
REQ-009 SHALL have port ld_lock  input  1  boot mode: when high, the CPU is never granted.
REQ-010 SHALL have memory ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_WIDTH; mem_wdata out WIDTH; mem_rdata in WIDTH (valid one cycle after mem_en).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-012 SHALL, in IDLE or RESP, arbitrate among pending requests, latch the winner's we/addr/wdata and owner, and enter ACCESS next cycle; with no eligible request, enter or stay in IDLE.
REQ-013 SHALL, in ACCESS, drive mem_en=1 with the latched mem_we/mem_addr/mem_wdata, pulse the owner's gnt for exactly one cycle, and enter RESP.
REQ-014 SHALL, in RESP, pulse the owner's rvalid for one cycle with rdata=mem_rdata for reads and for writes (write rdata is don't-care).
REQ-015 SHALL give requesters fixed latency: request sampled at edge t, gnt in cycle t+1, rvalid in cycle t+2; back-to-back accesses every 2 cycles.
REQ-016 SHALL require requesters to hold req and request fields stable until gnt; a req dropped before grant is ignored without error.
REQ-017 SHALL, under fixed priority, prefer the CPU over the loader.
REQ-018 SHALL keep an 8-bit wait counter that increments each arbitration cycle the loader is pending and loses, clears when the loader is granted, and saturates at 255.
REQ-019 SHALL grant the loader when the wait counter is at or above STARVE_LIMIT, regardless of cpu_req.
REQ-020 SHALL mask cpu_req while ld_lock=1; a lock raised mid-access SHALL NOT abort an in-flight CPU access.
REQ-021 SHALL hold all *_rdata outputs at their last values when not valid.

Reset
REQ-022 SHALL, on rst low, asynchronously force: state IDLE; wait counter 0; owner CPU; all gnt, rvalid and mem_en/mem_we outputs 0; mem_addr, mem_wdata and *_rdata 0; cpu_stall reflecting cpu_req only.
REQ-023 SHALL, on reset mid-access, issue no rvalid for the aborted access.
REQ-024 SHALL accept its first request at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL, when macro MEM_ARB_RR_EN is defined, replace fixed priority with round-robin: on a simultaneous request, the requester not granted last wins; the wait counter and STARVE_LIMIT have no effect.
REQ-026 SHALL, when MEM_ARB_RR_EN is undefined, use fixed priority with starvation override (REQ-017..019).

Structure
REQ-027 SHALL place the FSM state enum and the owner enum (OWN_CPU, OWN_LD) in shared package mem_arb_pkg.
REQ-028 SHALL use one sub-module, arb_pick, for the combinational winner selection (priority/RR/starvation).

Verification
REQ-029 SHALL cover: CPU read of addr 0x010, memory holds 0xDEADBEEF -> cpu_gnt at t+1, cpu_rvalid at t+2 with cpu_rdata=0xDEADBEEF.
REQ-030 SHALL cover: cpu_req and ld_req held high together, fixed priority, STARVE_LIMIT=3 -> grants CPU,CPU,CPU,LD, then counter 0.
REQ-031 SHALL cover: same stimulus with MEM_ARB_RR_EN -> grants alternate, starting with CPU after reset.
REQ-032 SHALL cover: ld_lock=1 with a loader write of 0x5 to addr 0x3FF and cpu_req high -> only ld_gnt; cpu_stall=1 throughout; mem_we=1 with mem_addr=0x3FF.
REQ-033 SHALL cover: rst pulled low in ACCESS -> next cycle all outputs 0 and no rvalid; first request after release is granted one cycle later.
